// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between fetch (F) and data (D).
// D has fixed priority; a skip counter forces F after MAX_WAIT D wins.
module mem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              f_done,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] SKIP_MAX =
    CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic                own_d_q, own_d_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    skip_q, skip_d;
  logic                f_done_q, f_done_d;
  logic                d_done_q, d_done_d;
  logic                force_f;

  // F is forced once D has won MAX_WAIT times in a row over a waiting F
  assign force_f = f_req && (skip_q == SKIP_MAX);

  // Next-state, grant latching and done decode
  always_comb begin
    state_d  = state_q;
    own_d_d  = own_d_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    skip_d   = skip_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && !force_f) begin
          state_d = ACCESS;
          own_d_d = 1'b1;
          addr_d  = d_addr;
          we_d    = d_we;
          wdata_d = d_wdata;
          if (!f_req)
            skip_d = '0;
          else if (skip_q != SKIP_MAX)
            skip_d = skip_q + 1'b1;
        end else if (f_req) begin
          state_d = ACCESS;
          own_d_d = 1'b0;
          addr_d  = f_addr;
          we_d    = 1'b0;
          skip_d  = '0;
        end
      end
      ACCESS: state_d = we_q ? DONE : WAIT;
      WAIT: begin
        rdata_d = mem_rdata;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
    endcase
    d_done_d = (state_d == DONE) && own_d_q;
    f_done_d = (state_d == DONE) && !own_d_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      own_d_q  <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      skip_q   <= '0;
      f_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      own_d_q  <= own_d_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      skip_q   <= skip_d;
      f_done_q <= f_done_d;
      d_done_q <= d_done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == ACCESS) && we_q;
  assign busy      = (state_q != IDLE);
  assign rdata     = rdata_q;
  assign f_done    = f_done_q;
  assign d_done    = d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level arbitration and memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        f_req;
  logic [7:0]  f_addr;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [15:0] d_wdata;
  logic        f_done;
  logic        d_done;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;
  logic [15:0] ram [256];

  int n_cmp;
  int n_err;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .f_done    (f_done),
    .d_done    (d_done),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 if (clk_en) clk = ~clk;
  end

  // Synchronous RAM with registered read and a backdoor write port
  always @(posedge clk) begin
    if (bd_we)
      ram[bd_addr] <= bd_data;
    else if (mem_we)
      ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a,
                      input logic [15:0] v);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = v;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({f_done, d_done, busy, mem_we, mem_addr,
         mem_wdata, rdata} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0",
               {f_done, d_done, busy, mem_we, mem_addr,
                mem_wdata, rdata});
    end
    clk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({busy, mem_we, f_done, d_done} !== 4'b0) begin
        n_err++;
        $display("FAIL idle_after_reset: busy/we/fd/dd=%b want 0000",
                 {busy, mem_we, f_done, d_done});
      end
    end
  endtask

  task automatic test_fetch_read();
    poke(8'h10, 16'hBEEF);
    f_req  = 1'b1;
    f_addr = 8'h10;
    tick();
    n_cmp++;
    if ({mem_addr, mem_we, busy} !== {8'h10, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL fetch_c1: addr=%h we=%b busy=%b want 10/0/1",
               mem_addr, mem_we, busy);
    end
    f_addr = 8'h77;
    tick();
    n_cmp++;
    if ({f_done, mem_we} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_c2: f_done=%b we=%b want 0/0",
               f_done, mem_we);
    end
    tick();
    n_cmp++;
    if ({f_done, d_done, rdata} !== {2'b10, 16'hBEEF}) begin
      n_err++;
      $display("FAIL fetch_c3: fd=%b dd=%b rdata=%h want 1/0/beef",
               f_done, d_done, rdata);
    end
    f_req = 1'b0;
    tick();
    n_cmp++;
    if ({f_done, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL fetch_c4: f_done=%b busy=%b want 0/0",
               f_done, busy);
    end
  endtask

  task automatic test_write_then_fetch();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h20;
    d_wdata = 16'h1234;
    tick();
    d_wdata = 16'hFFFF;
    n_cmp++;
    if ({mem_we, mem_addr, mem_wdata} !==
        {1'b1, 8'h20, 16'h1234}) begin
      n_err++;
      $display("FAIL write_c1: we=%b addr=%h wd=%h want 1/20/1234",
               mem_we, mem_addr, mem_wdata);
    end
    tick();
    n_cmp++;
    if ({mem_we, d_done, f_done} !== 3'b010) begin
      n_err++;
      $display("FAIL write_c2: we=%b dd=%b fd=%b want 0/1/0",
               mem_we, d_done, f_done);
    end
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    f_req  = 1'b1;
    f_addr = 8'h20;
    tick();
    tick();
    tick();
    n_cmp++;
    if ({f_done, rdata} !== {1'b1, 16'h1234}) begin
      n_err++;
      $display("FAIL write_readback: fd=%b rdata=%h want 1/1234",
               f_done, rdata);
    end
    f_req = 1'b0;
    tick();
  endtask

  task automatic test_simultaneous();
    int dc, fc;
    logic [15:0] dr, fr;
    poke(8'h05, 16'h00AA);
    dc = -1;
    fc = -1;
    dr = '0;
    fr = '0;
    f_req  = 1'b1;
    f_addr = 8'h10;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 8'h05;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (d_done) begin
        dc = i;
        dr = rdata;
        d_req = 1'b0;
      end
      if (f_done) begin
        fc = i;
        fr = rdata;
        f_req = 1'b0;
      end
    end
    n_cmp++;
    if (dc !== 3 || dr !== 16'h00AA) begin
      n_err++;
      $display("FAIL simul_d: d_done at %0d rdata=%h want 3/00aa",
               dc, dr);
    end
    n_cmp++;
    if (fc - dc !== 4 || fr !== 16'hBEEF) begin
      n_err++;
      $display("FAIL simul_f: f-d gap %0d rdata=%h want 4/beef",
               fc - dc, fr);
    end
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_starvation();
    logic [5:0]  seq;
    logic [15:0] fr;
    int          cnt;
    bit          rearm;
    seq   = '0;
    fr    = '0;
    cnt   = 0;
    rearm = 1'b0;
    f_req   = 1'b1;
    f_addr  = 8'h10;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h30;
    d_wdata = 16'($urandom);
    for (int i = 0; i < 80 && cnt < 6; i++) begin
      tick();
      if (rearm) begin
        d_req   = 1'b1;
        d_wdata = 16'($urandom);
        rearm   = 1'b0;
      end
      if (d_done) begin
        seq   = {seq[4:0], 1'b1};
        cnt++;
        d_req = 1'b0;
        rearm = 1'b1;
      end
      if (f_done) begin
        seq   = {seq[4:0], 1'b0};
        cnt++;
        fr    = rdata;
        f_req = 1'b0;
      end
    end
    d_req = 1'b0;
    f_req = 1'b0;
    n_cmp++;
    if (cnt !== 6 || seq !== 6'b111101) begin
      n_err++;
      $display("FAIL starvation_order: n=%0d seq=%b want 6/111101",
               cnt, seq);
    end
    n_cmp++;
    if (fr !== 16'hBEEF) begin
      n_err++;
      $display("FAIL starvation_fetch: rdata=%h want beef", fr);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    poke(8'h40, 16'h0000);
    f_req  = 1'b1;
    f_addr = 8'h10;
    tick();
    tick();
    #1;
    rst   = 1'b1;
    f_req = 1'b0;
    #1;
    n_cmp++;
    if ({busy, mem_we, f_done} !== 3'b000) begin
      n_err++;
      $display("FAIL rst_wait: busy=%b we=%b fd=%b want 000",
               busy, mem_we, f_done);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({f_done, d_done, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL rst_wait_after: fd/dd/busy=%b want 000",
                 {f_done, d_done, busy});
      end
    end
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 8'h40;
    d_wdata = 16'h5555;
    tick();
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_err++;
      $display("FAIL rst_access_pre: we=%b want 1", mem_we);
    end
    #1;
    rst   = 1'b1;
    d_req = 1'b0;
    d_we  = 1'b0;
    #1;
    n_cmp++;
    if ({mem_we, busy, mem_addr} !== 10'd0) begin
      n_err++;
      $display("FAIL rst_access: we=%b busy=%b addr=%h want 0/0/00",
               mem_we, busy, mem_addr);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if ({f_done, d_done, busy} !== 3'b000) begin
        n_err++;
        $display("FAIL rst_access_after: fd/dd/busy=%b want 000",
                 {f_done, d_done, busy});
      end
    end
    n_cmp++;
    if (ram[8'h40] !== 16'h0000) begin
      n_err++;
      $display("FAIL rst_partial_write: ram=%h want 0000",
               ram[8'h40]);
    end
  endtask

  task automatic test_random();
    logic [15:0] mdl [16];
    int          free_at, g, f_at, d_at, skip;
    bit          gw, d_rd;
    logic [7:0]  ga;
    logic [15:0] f_exp, d_exp;
    for (int i = 0; i < 16; i++) begin
      poke(8'(i), 16'h0000);
      mdl[i] = 16'h0000;
    end
    free_at = 0;
    g       = -10;
    f_at    = -1;
    d_at    = -1;
    skip    = 0;
    gw      = 1'b0;
    d_rd    = 1'b0;
    ga      = '0;
    f_exp   = '0;
    d_exp   = '0;
    f_req   = 1'b0;
    d_req   = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      n_cmp++;
      if (f_done !== (c == f_at)) begin
        n_err++;
        $display("FAIL rnd_f_done c=%0d: got %b want %b",
                 c, f_done, c == f_at);
      end
      n_cmp++;
      if (d_done !== (c == d_at)) begin
        n_err++;
        $display("FAIL rnd_d_done c=%0d: got %b want %b",
                 c, d_done, c == d_at);
      end
      n_cmp++;
      if (busy !== (c > g && c < free_at)) begin
        n_err++;
        $display("FAIL rnd_busy c=%0d: got %b want %b",
                 c, busy, c > g && c < free_at);
      end
      n_cmp++;
      if (mem_we !== (c == g + 1 && gw)) begin
        n_err++;
        $display("FAIL rnd_mem_we c=%0d: got %b want %b",
                 c, mem_we, c == g + 1 && gw);
      end
      if (c == g + 1) begin
        n_cmp++;
        if (mem_addr !== ga) begin
          n_err++;
          $display("FAIL rnd_mem_addr c=%0d: got %h want %h",
                   c, mem_addr, ga);
        end
      end
      if (c == f_at) begin
        n_cmp++;
        if (rdata !== f_exp) begin
          n_err++;
          $display("FAIL rnd_f_rdata c=%0d: got %h want %h",
                   c, rdata, f_exp);
        end
      end
      if (c == d_at && d_rd) begin
        n_cmp++;
        if (rdata !== d_exp) begin
          n_err++;
          $display("FAIL rnd_d_rdata c=%0d: got %h want %h",
                   c, rdata, d_exp);
        end
      end
      if (f_req && c == f_at)
        f_req = 1'b0;
      else if (!f_req && $urandom_range(3) == 0) begin
        f_req  = 1'b1;
        f_addr = 8'($urandom_range(15));
      end
      if (d_req && c == d_at)
        d_req = 1'b0;
      else if (!d_req && $urandom_range(2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(1));
        d_addr  = 8'($urandom_range(15));
        d_wdata = 16'($urandom);
      end
      if (c >= free_at) begin
        if (d_req && !(f_req && skip == 4)) begin
          g    = c;
          gw   = d_we;
          ga   = d_addr;
          skip = f_req ? ((skip < 4) ? skip + 1 : 4) : 0;
          d_rd = !d_we;
          d_at = c + (d_we ? 2 : 3);
          if (d_we)
            mdl[d_addr[3:0]] = d_wdata;
          else
            d_exp = mdl[d_addr[3:0]];
          free_at = d_at + 1;
        end else if (f_req) begin
          g       = c;
          gw      = 1'b0;
          ga      = f_addr;
          skip    = 0;
          f_at    = c + 3;
          f_exp   = mdl[f_addr[3:0]];
          free_at = f_at + 1;
        end
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clk_en  = 1'b0;
    rst     = 1'b1;
    f_req   = 1'b0;
    f_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    test_reset();
    test_fetch_read();
    test_write_then_fetch();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
